systolic_matmul: RTL and testbench
==================================

SYSTOLIC_MATMUL -- requirements
Module: systolic_matmul

Interface
REQ-001 Parameter N, default 4, array dimension: computes C = A x B for NxN matrices, N >= 2.
REQ-002 Parameter DATA_W, default 8, element width of A and B.
REQ-003 Parameter ACC_W, default 2*DATA_W+$clog2(N), accumulator/result width.
REQ-004 clk  input  1  clock; all logic SHALL be on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle request to begin a new multiplication.
REQ-007 in_valid  input  1  a_col/b_row beat is valid.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 a_col  input  N*DATA_W  column k of A; slice i = A[i][k].
REQ-010 b_row  input  N*DATA_W  row k of B; slice j = B[k][j].
REQ-011 busy  output  1  high in LOAD and DRAIN.
REQ-012 done  output  1  one-cycle pulse when results are complete.
REQ-013 c_flat  output  N*N*ACC_W  result; slice (i*N+j) = C[i][j].

Function
REQ-014 FSM states SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-015 IDLE + start: zero all accumulators and skew registers; go to LOAD next cycle.
REQ-016 start SHALL be ignored in LOAD, DRAIN and DONE.
REQ-017 in_ready = 1 only in LOAD; beat accepted on in_valid && in_ready; beat counter k counts 0..N-1.
REQ-018 LOAD cycle with in_valid=0: zeros SHALL be injected into all row/column inputs (bubble); products unaffected.
REQ-019 Acceptance of beat k = N-1 SHALL move FSM to DRAIN with drain counter loaded to 2N-1.
REQ-020 Row i of A delayed i cycles, column j of B delayed j cycles (skew registers) before entering the array.
REQ-021 Array is NxN output-stationary PEs: A moves right, B moves down, one register per PE hop.
REQ-022 Product of the beat accepted at edge E SHALL be accumulated in PE(i,j) at edge E+i+j+1.
REQ-023 DRAIN injects zeros, decrements each cycle, goes to DONE when counter reaches 0.
REQ-024 DONE lasts exactly one cycle with done=1, then IDLE; done=0 in all other states.
REQ-025 c_flat SHALL be valid from the DONE cycle and held unchanged until the next accepted start.
REQ-026 Products and sums unsigned, zero-extended to ACC_W; ACC_W default guarantees no overflow.
REQ-027 ACC_W smaller than default: results wrap modulo 2^ACC_W, no saturation.

Reset
REQ-028 reset SHALL force IDLE, beat/drain counters 0, all skew, pipeline and accumulator registers 0.
REQ-029 Reset outputs: in_ready=0, busy=0, done=0, c_flat=0.
REQ-030 reset asserted mid-LOAD/DRAIN SHALL abandon the operation with no done pulse; reset overrides start.

Configuration
REQ-031 Macro SYSTOLIC_SIGNED_EN defined: A, B treated as two's-complement, products sign-extended to ACC_W, c_flat signed.
REQ-032 Macro SYSTOLIC_SIGNED_EN undefined: unsigned arithmetic as REQ-026; latency and handshake identical in both builds.

Structure
REQ-033 Package systolic_pkg SHALL hold the FSM state enum and a function computing default ACC_W from N and DATA_W.
REQ-034 Sub-module systolic_pe (parameters DATA_W, ACC_W; ports clk, reset, clr, in_a, in_b, out_a, out_b, acc) SHALL be instantiated NxN via generate.
REQ-035 FSM, counters and skew registers SHALL reside in systolic_matmul.

Verification
REQ-036 N=4, A=identity, B[k][j]=4k+j+1, in_valid continuous -> C=B; done exactly 2N-1+1 cycles after last beat accepted.
REQ-037 N=4, DATA_W=8, all elements 255 -> every C[i][j]=260100, no wrap at ACC_W=18.
REQ-038 Same as REQ-036 with in_valid low for 2 cycles between each beat -> identical C; done delayed by bubble count.
REQ-039 start pulsed during LOAD and DRAIN -> ignored; one done pulse; C unchanged.
REQ-040 reset asserted after beat 2 -> outputs 0, IDLE; following clean run yields correct C.
REQ-041 SYSTOLIC_SIGNED_EN, N=4: A all -128, B all -128 -> C=65536; A all -128, B all 127 -> C=-65024.

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic matrix multiplier.
// FSM state enum plus the default accumulator width rule.
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Wide enough that N full-scale products can never overflow.
   function automatic int acc_width(input int n, input int data_w);
      return 2 * data_w + $clog2(n);
   endfunction

endpackage

// File: rtl/systolic_matmul_if.sv
// Handshake and data bundle for systolic_matmul; master drives beats, slave is the array.
interface systolic_matmul_if
   import systolic_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = acc_width(N, DATA_W)
);
   logic                   start;
   logic                   in_valid;
   logic                   in_ready;
   logic [N*DATA_W-1:0]    a_col;
   logic [N*DATA_W-1:0]    b_row;
   logic                   busy;
   logic                   done;
   logic [N*N*ACC_W-1:0]   c_flat;

   modport master (
      output start, in_valid, a_col, b_row,
      input  in_ready, busy, done, c_flat
   );

   modport slave (
      input  start, in_valid, a_col, b_row,
      output in_ready, busy, done, c_flat
   );
endinterface

// File: rtl/systolic_pe.sv
// Output-stationary processing element: forwards A right and B down, accumulates A*B.
// SYSTOLIC_SIGNED_EN selects two's-complement products instead of unsigned ones.
module systolic_pe #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [ACC_W-1:0]  acc
);

   logic [ACC_W-1:0] prod;

`ifdef SYSTOLIC_SIGNED_EN
   logic signed [2*DATA_W-1:0] prod_full;
   assign prod_full = $signed({{DATA_W{in_a[DATA_W-1]}}, in_a}) *
                      $signed({{DATA_W{in_b[DATA_W-1]}}, in_b});
   assign prod = ACC_W'(prod_full);
`else
   logic [2*DATA_W-1:0] prod_full;
   assign prod_full = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
   assign prod = ACC_W'(prod_full);
`endif

   // Accumulation wraps modulo 2^ACC_W when ACC_W is narrowed.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         out_a <= '0;
         out_b <= '0;
         acc   <= '0;
      end else begin
         out_a <= in_a;
         out_b <= in_b;
         acc   <= acc + prod;
      end
   end

endmodule

// File: rtl/systolic_matmul.sv
// NxN output-stationary systolic multiplier C = A x B fed one A column / B row per beat.
// Define SYSTOLIC_SIGNED_EN for two's-complement operands (handled inside systolic_pe).
module systolic_matmul
   import systolic_pkg::*;
#(
   parameter int N      = 4,
   parameter int DATA_W = 8,
   parameter int ACC_W  = acc_width(N, DATA_W)
) (
   input  logic             clk,
   input  logic             reset,
   systolic_matmul_if.slave bus
);

   localparam int KW = $clog2(N);
   localparam int DW = $clog2(2 * N);

   state_t          state, state_nx;
   logic [KW-1:0]   beat_cnt;
   logic [DW-1:0]   drain_cnt;
   logic            accept;
   logic            last_beat;
   logic            clr;

   logic [DATA_W-1:0] a_h [N][N+1];
   logic [DATA_W-1:0] b_v [N+1][N];

   assign accept    = (state == LOAD) && bus.in_valid;
   assign last_beat = accept && (beat_cnt == KW'(N - 1));
   assign clr       = (state == IDLE) && bus.start;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = LOAD;
         LOAD:    if (last_beat) state_nx = DRAIN;
         DRAIN:   if (drain_cnt == '0) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.in_ready = (state == LOAD);
   assign bus.busy     = (state == LOAD) || (state == DRAIN);
   assign bus.done     = (state == DONE);

   // Drain runs 2N-1 cycles so the last beat reaches PE(N-1,N-1) before DONE.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         beat_cnt  <= '0;
         drain_cnt <= '0;
      end else begin
         if (last_beat) begin
            beat_cnt  <= '0;
            drain_cnt <= DW'(2 * N - 1);
         end else if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
         end else if ((state == DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - 1'b1;
         end
      end
   end

   // Row/column i gets i+1 registers: capture stage plus i cycles of skew.
   for (genvar i = 0; i < N; i++) begin : g_skew
      logic [DATA_W-1:0] a_sk [i+1];
      logic [DATA_W-1:0] b_sk [i+1];

      always_ff @(posedge clk) begin
         if (reset || clr) begin
            for (int s = 0; s <= i; s++) begin
               a_sk[s] <= '0;
               b_sk[s] <= '0;
            end
         end else begin
            a_sk[0] <= accept ? bus.a_col[i*DATA_W +: DATA_W] : '0;
            b_sk[0] <= accept ? bus.b_row[i*DATA_W +: DATA_W] : '0;
            for (int s = 1; s <= i; s++) begin
               a_sk[s] <= a_sk[s-1];
               b_sk[s] <= b_sk[s-1];
            end
         end
      end

      assign a_h[i][0] = a_sk[i];
      assign b_v[0][i] = b_sk[i];
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         logic [ACC_W-1:0] acc_ij;

         systolic_pe #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W)
         ) u_pe (
            .clk   (clk),
            .reset (reset),
            .clr   (clr),
            .in_a  (a_h[i][j]),
            .in_b  (b_v[i][j]),
            .out_a (a_h[i][j+1]),
            .out_b (b_v[i+1][j]),
            .acc   (acc_ij)
         );

         assign bus.c_flat[(i*N+j)*ACC_W +: ACC_W] = acc_ij;
      end
   end

endmodule

// File: tb/tb_systolic_matmul.sv
// Directed self-checking bench for systolic_matmul (N=4, DATA_W=8, default ACC_W).
module tb_systolic_matmul;
   import systolic_pkg::*;

   localparam int N      = 4;
   localparam int DATA_W = 8;
   localparam int ACC_W  = acc_width(N, DATA_W);
   localparam int CW     = N * N * ACC_W;
   localparam logic [N*DATA_W-1:0] JUNK = {N{8'hA5}};

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   systolic_matmul_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

   systolic_matmul #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [DATA_W-1:0] mat_a [N][N];
   logic [DATA_W-1:0] mat_b [N][N];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // A = identity, B[k][j] = N*k+j+1, so C is B itself.
   task automatic load_identity();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mat_a[r][c] = (r == c) ? DATA_W'(1) : DATA_W'(0);
            mat_b[r][c] = DATA_W'(N * r + c + 1);
         end
   endtask

   task automatic load_uniform(input logic [DATA_W-1:0] av, input logic [DATA_W-1:0] bv);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mat_a[r][c] = av;
            mat_b[r][c] = bv;
         end
   endtask

   function automatic logic [CW-1:0] flat_of_b();
      logic [CW-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            r[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(mat_b[i][j]);
      return r;
   endfunction

   function automatic logic [CW-1:0] flat_uniform(input logic [ACC_W-1:0] v);
      logic [CW-1:0] r;
      for (int e = 0; e < N * N; e++) r[e*ACC_W +: ACC_W] = v;
      return r;
   endfunction

   function automatic logic [CW-1:0] ref_matmul();
      logic [CW-1:0] r;
      int s;
      r = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) begin
`ifdef SYSTOLIC_SIGNED_EN
               s += int'($signed(mat_a[i][k])) * int'($signed(mat_b[k][j]));
`else
               s += int'(mat_a[i][k]) * int'(mat_b[k][j]);
`endif
            end
            r[(i*N+j)*ACC_W +: ACC_W] = ACC_W'(s);
         end
      return r;
   endfunction

   // Runs one multiplication; returns with the DONE cycle current (or after a timeout).
   task automatic applyStimulus(input int gap, input bit poke, output int total,
                                output int tail, output bit seen);
      total = 0;
      tail  = 0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (k > 0) begin
            for (int g = 0; g < gap; g++) begin
               bus.in_valid = 1'b0;
               bus.a_col    = JUNK;
               bus.b_row    = JUNK;
               tick();
               total++;
            end
         end
         bus.in_valid = 1'b1;
         for (int i = 0; i < N; i++) begin
            bus.a_col[i*DATA_W +: DATA_W] = mat_a[i][k];
            bus.b_row[i*DATA_W +: DATA_W] = mat_b[k][i];
         end
         bus.start = poke;
         tick();
         total++;
         bus.start = 1'b0;
      end
      bus.in_valid = 1'b0;
      bus.a_col    = JUNK;
      bus.b_row    = JUNK;
      while (!bus.done && tail < 100) begin
         bus.start = poke && (tail == 2);
         tick();
         tail++;
         total++;
      end
      bus.start = 1'b0;
      seen = bus.done;
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b1;
      repeat (2) tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready got %0b want 0", bus.in_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", bus.done); end
      checks++; if (bus.c_flat !== '0) begin errors++; $display("[TB] FAIL reset_c_flat got %h want 0", bus.c_flat); end
      bus.start = 1'b0;
      reset     = 1'b0;
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_over_start got in_ready %0b want 0", bus.in_ready); end
   endtask

   task automatic test_identity();
      int total, tail;
      bit seen;
      logic [CW-1:0] exp_c;
      load_identity();
      exp_c = flat_of_b();
      applyStimulus(0, 1'b0, total, tail, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL ident_done_seen got %0b want 1", seen); end
      checks++; if (tail !== 2 * N) begin errors++; $display("[TB] FAIL ident_latency got %0d want %0d", tail, 2 * N); end
      checks++; if (total !== 3 * N) begin errors++; $display("[TB] FAIL ident_total got %0d want %0d", total, 3 * N); end
      checks++; if (bus.c_flat !== exp_c) begin errors++; $display("[TB] FAIL ident_c got %h want %h", bus.c_flat, exp_c); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL ident_busy_at_done got %0b want 0", bus.busy); end
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL ident_done_pulse got %0b want 0", bus.done); end
      repeat (3) tick();
      checks++; if (bus.c_flat !== exp_c) begin errors++; $display("[TB] FAIL ident_c_hold got %h want %h", bus.c_flat, exp_c); end
   endtask

   task automatic test_bubbles();
      int total, tail;
      bit seen;
      logic [CW-1:0] exp_c;
      load_identity();
      exp_c = flat_of_b();
      applyStimulus(2, 1'b0, total, tail, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL bubble_done_seen got %0b want 1", seen); end
      checks++; if (tail !== 2 * N) begin errors++; $display("[TB] FAIL bubble_latency got %0d want %0d", tail, 2 * N); end
      checks++; if (total !== 3 * N + 2 * (N - 1)) begin errors++; $display("[TB] FAIL bubble_total got %0d want %0d", total, 3 * N + 2 * (N - 1)); end
      checks++; if (bus.c_flat !== exp_c) begin errors++; $display("[TB] FAIL bubble_c got %h want %h", bus.c_flat, exp_c); end
      tick();
   endtask

   task automatic test_general();
      int total, tail;
      bit seen;
      logic [CW-1:0] exp_c;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            mat_a[r][c] = DATA_W'(r * N + c + 1);
            mat_b[r][c] = DATA_W'(((r + 3 * c) % 7) + 1);
         end
      exp_c = ref_matmul();
      applyStimulus(1, 1'b0, total, tail, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL general_done_seen got %0b want 1", seen); end
      checks++; if (bus.c_flat !== exp_c) begin errors++; $display("[TB] FAIL general_c got %h want %h", bus.c_flat, exp_c); end
      tick();
   endtask

`ifdef SYSTOLIC_SIGNED_EN
   task automatic test_signed();
      int total, tail;
      bit seen;
      load_uniform(8'h80, 8'h80);
      applyStimulus(0, 1'b0, total, tail, seen);
      checks++; if (bus.c_flat !== flat_uniform(ACC_W'(65536))) begin errors++; $display("[TB] FAIL signed_neg_neg got %h want %h", bus.c_flat, flat_uniform(ACC_W'(65536))); end
      tick();
      load_uniform(8'h80, 8'h7F);
      applyStimulus(0, 1'b0, total, tail, seen);
      checks++; if (bus.c_flat !== flat_uniform(ACC_W'(-65024))) begin errors++; $display("[TB] FAIL signed_neg_pos got %h want %h", bus.c_flat, flat_uniform(ACC_W'(-65024))); end
      tick();
   endtask
`else
   task automatic test_full_scale();
      int total, tail;
      bit seen;
      load_uniform(8'hFF, 8'hFF);
      applyStimulus(0, 1'b0, total, tail, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL full_done_seen got %0b want 1", seen); end
      checks++; if (bus.c_flat !== flat_uniform(ACC_W'(260100))) begin errors++; $display("[TB] FAIL full_scale_c got %h want %h", bus.c_flat, flat_uniform(ACC_W'(260100))); end
      tick();
   endtask
`endif

   task automatic test_start_ignored();
      int total, tail;
      bit seen;
      logic [CW-1:0] exp_c;
      load_identity();
      exp_c = flat_of_b();
      applyStimulus(1, 1'b1, total, tail, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL ignore_done_seen got %0b want 1", seen); end
      checks++; if (tail !== 2 * N) begin errors++; $display("[TB] FAIL ignore_latency got %0d want %0d", tail, 2 * N); end
      checks++; if (bus.c_flat !== exp_c) begin errors++; $display("[TB] FAIL ignore_c got %h want %h", bus.c_flat, exp_c); end
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL ignore_single_done got %0b want 0", bus.done); end
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL ignore_start_in_done got in_ready %0b want 0", bus.in_ready); end
      checks++; if (bus.c_flat !== exp_c) begin errors++; $display("[TB] FAIL ignore_c_hold got %h want %h", bus.c_flat, exp_c); end
   endtask

   task automatic test_reset_mid_load();
      int total, tail, dones;
      bit seen;
      logic [CW-1:0] exp_c;
      load_identity();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.in_valid = 1'b1;
         for (int i = 0; i < N; i++) begin
            bus.a_col[i*DATA_W +: DATA_W] = mat_a[i][k];
            bus.b_row[i*DATA_W +: DATA_W] = mat_b[k][i];
         end
         tick();
      end
      bus.in_valid = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL midrst_in_ready got %0b want 0", bus.in_ready); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %0b want 0", bus.busy); end
      checks++; if (bus.c_flat !== '0) begin errors++; $display("[TB] FAIL midrst_c_flat got %h want 0", bus.c_flat); end
      dones = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.done === 1'b1) dones++;
      end
      checks++; if (dones !== 0) begin errors++; $display("[TB] FAIL midrst_no_done got %0d pulses want 0", dones); end
      exp_c = flat_of_b();
      applyStimulus(0, 1'b0, total, tail, seen);
      checks++; if (seen !== 1'b1) begin errors++; $display("[TB] FAIL midrst_rerun_done got %0b want 1", seen); end
      checks++; if (bus.c_flat !== exp_c) begin errors++; $display("[TB] FAIL midrst_rerun_c got %h want %h", bus.c_flat, exp_c); end
      tick();
   endtask

   initial begin
      reset        = 1'b1;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.a_col    = '0;
      bus.b_row    = '0;
      test_reset();
      test_identity();
      test_bubbles();
      test_general();
`ifdef SYSTOLIC_SIGNED_EN
      test_signed();
`else
      test_full_scale();
`endif
      test_start_ignored();
      test_reset_mid_load();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
